bcd_carpma: RTL and testbench
=============================

Name: bcd_carpma

Overview:
- Sequential inverse of the kesirlibolme divider. It takes the three BCD digits that kesirlibolme emits (rakam1 = hundreds, rakam2 = tens, rakam3 = units) and a 6-bit multiplier (bolen).
- It rebuilds the binary value, multiplies it by bolen, and reports the 16-bit product.
- The divider bench uses it for round-trip checks: bolunen ≈ digits × bolen.
- Start/busy/done handshake; multi-cycle shift-add datapath.

Parameters:
- BOLEN_W, 6, multiplier width.
- SONUC_W, 16, product width; must be ≥ 10 + BOLEN_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- basla  input  1  start request, sampled only in IDLE.
- rakam1  input  4  BCD hundreds digit.
- rakam2  input  4  BCD tens digit.
- rakam3  input  4  BCD units digit.
- bolen  input  BOLEN_W  multiplier.
- carpim  output  SONUC_W  product; held stable until the next completion.
- mesgul  output  1  high while in CEVIR or CARP.
- bitti  output  1  one-cycle completion pulse.
- hata  output  1  invalid BCD flag; valid while bitti=1, held until the next start.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: carpim=0, mesgul=0, bitti=0, hata=0, state=IDLE, all internal registers 0. Reset asserted mid-operation aborts immediately with no bitti pulse; after release the block waits in IDLE for a new basla.
- States: IDLE, CEVIR, CARP, BITTI.
- IDLE:
  - On a clk edge with basla=1, capture rakam1..3 and bolen into internal registers and clear hata.
  - If any digit > 9: go to BITTI with hata=1 and carpim=0.
  - Otherwise: go to CEVIR with acc=0 and digit index=0.
- CEVIR, 3 cycles:
  - Each cycle acc <= acc*10 + digit[index], hundreds first.
  - Implement acc*10 as (acc<<3) + (acc<<1); acc is 10 bits wide (max 999).
  - After the third cycle go to CARP with product register=0 and bit counter=0.
- CARP, BOLEN_W cycles, LSB-first shift-add:
  - If the multiplier LSB is 1, add the shifted multiplicand to the product.
  - Then shift the multiplicand left and the multiplier right.
  - Product register is SONUC_W wide; no overflow is possible given the parameter rule.
  - After BOLEN_W cycles go to BITTI.
- BITTI, 1 cycle:
  - carpim <= product (or 0 on error), bitti=1, mesgul=0.
  - Next state IDLE.
- Latency:
  - Valid digits: bitti is high in the cycle after the (3 + BOLEN_W + 1)th edge following the start edge. With defaults that is 10 edges.
  - Invalid digits: bitti follows at the next edge (1 edge).
- basla while mesgul=1 or during BITTI is ignored; it is not queued.
- basla asserted in the cycle immediately after bitti is accepted normally, so back-to-back operations work.
- Input changes after capture have no effect on the running operation.
- bolen=0 or all digits 0 runs the full latency and gives carpim=0, hata=0.
- carpim only changes in BITTI; it does not change on reset release or on start.

Decomposition:
- Shared package bcd_pkg:
  - state typedef/encoding (IDLE=0, CEVIR=1, CARP=2, BITTI=3);
  - BCD_MAX=9, RAKAM_SAYISI=3, RAKAM_W=4;
  - constant ACC_W=10 for the decimal accumulator.
- One natural sub-module: bcd_gecerli, a combinational check that flags any digit > 9. The same check is reused by the kesirlibolme bench.
- The FSM and shift-add datapath stay in bcd_carpma.

Test Plan:
- Digits 1,2,5, bolen=4, basla pulse:
  - mesgul is high for 9 cycles, then bitti pulses once;
  - carpim=500 (10'b0111110100), hata=0.
- Digits 0,0,8, bolen=3: carpim=24, bitti 10 edges after start.
- Digits 9,9,9, bolen=63: carpim=62937 with no truncation.
- Digits 1,10,0 (i.e. 4'hA), bolen=5:
  - bitti at the first edge after start, hata=1, carpim=0;
  - a following valid start clears hata.
- basla held high throughout two operations (1,2,5×4 then inputs changed to 0,2,5×3 mid-run):
  - first result is 500, unaffected by the mid-run change;
  - second start is accepted the cycle after bitti;
  - second result is 75.
- rst pulsed during CARP:
  - all outputs return to 0 asynchronously, with no bitti;
  - a new start then completes correctly (e.g. 2,5,0×2 → 500).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary multiplier and its BCD validity check.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CEVIR = 2'd1,
    CARP  = 2'd2,
    BITTI = 2'd3
  } durum_t;

  localparam int BCD_MAX      = 9;
  localparam int RAKAM_SAYISI = 3;
  localparam int RAKAM_W      = 4;
  localparam int ACC_W        = 10;

endpackage

// File: rtl/bcd_gecerli.sv
// Combinational BCD validity check: flags any digit above 9.
module bcd_gecerli
  import bcd_pkg::*;
(
  input  logic [RAKAM_SAYISI-1:0][RAKAM_W-1:0] rakamlar,
  output logic                                 gecersiz
);

  // Raise the flag if any digit falls outside 0..9
  always_comb begin
    gecersiz = 1'b0;
    for (int i = 0; i < RAKAM_SAYISI; i++) begin
      if (rakamlar[i] > RAKAM_W'(BCD_MAX)) gecersiz = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_carpma.sv
// Rebuilds a 3-digit BCD value in binary and multiplies it by bolen with an
// LSB-first shift-add loop, behind a basla/mesgul/bitti handshake.
module bcd_carpma
  import bcd_pkg::*;
#(
  parameter int BOLEN_W = 6,
  parameter int SONUC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               basla,
  input  logic [3:0]         rakam1,
  input  logic [3:0]         rakam2,
  input  logic [3:0]         rakam3,
  input  logic [BOLEN_W-1:0] bolen,
  output logic [SONUC_W-1:0] carpim,
  output logic               mesgul,
  output logic               bitti,
  output logic               hata
);

  localparam int CNT_W = $clog2(BOLEN_W + 1);

  durum_t                              durum_q, durum_d;
  logic [RAKAM_SAYISI-1:0][RAKAM_W-1:0] rakam_q, rakam_d;
  logic [ACC_W-1:0]                    acc_q, acc_d;
  logic [1:0]                          idx_q, idx_d;
  logic [SONUC_W-1:0]                  mcand_q, mcand_d;
  logic [SONUC_W-1:0]                  prod_q, prod_d;
  logic [SONUC_W-1:0]                  carpim_q, carpim_d;
  logic [BOLEN_W-1:0]                  mplier_q, mplier_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic                                hata_q, hata_d;

  logic [RAKAM_SAYISI-1:0][RAKAM_W-1:0] giris;
  logic                                 gecersiz;
  logic [RAKAM_W-1:0]                   secili;

  // Index 0 holds the hundreds digit so conversion walks most-significant first
  assign giris = {rakam3, rakam2, rakam1};

  bcd_gecerli u_gecerli (
    .rakamlar (giris),
    .gecersiz (gecersiz)
  );

  // Pick the captured digit that the conversion step consumes this cycle
  always_comb begin
    secili = rakam_q[0];
    case (idx_q)
      2'd1:    secili = rakam_q[1];
      2'd2:    secili = rakam_q[2];
      default: secili = rakam_q[0];
    endcase
  end

  // Next-state and datapath updates for the capture/convert/multiply/report sequence
  always_comb begin
    durum_d  = durum_q;
    rakam_d  = rakam_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    carpim_d = carpim_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hata_d   = hata_q;

    unique case (durum_q)
      IDLE: begin
        if (basla) begin
          rakam_d  = giris;
          mplier_d = bolen;
          hata_d   = 1'b0;
          acc_d    = '0;
          idx_d    = '0;
          if (gecersiz) begin
            hata_d   = 1'b1;
            carpim_d = '0;
            durum_d  = BITTI;
          end else begin
            durum_d = CEVIR;
          end
        end
      end

      CEVIR: begin
        // acc*10 as (acc<<3)+(acc<<1); the accumulator never exceeds 999
        acc_d = (acc_q << 3) + (acc_q << 1) + ACC_W'(secili);
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'(RAKAM_SAYISI - 1)) begin
          mcand_d = SONUC_W'(acc_d);
          prod_d  = '0;
          cnt_d   = '0;
          durum_d = CARP;
        end
      end

      CARP: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BOLEN_W - 1)) begin
          // Load the result on entry so it is already valid while bitti is high
          carpim_d = prod_d;
          durum_d  = BITTI;
        end
      end

      BITTI: begin
        durum_d = IDLE;
      end

      default: durum_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any running operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q  <= IDLE;
      rakam_q  <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      carpim_q <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hata_q   <= 1'b0;
    end else begin
      durum_q  <= durum_d;
      rakam_q  <= rakam_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      carpim_q <= carpim_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hata_q   <= hata_d;
    end
  end

  assign carpim = carpim_q;
  assign hata   = hata_q;
  assign mesgul = (durum_q == CEVIR) || (durum_q == CARP);
  assign bitti  = (durum_q == BITTI);

endmodule

// File: tb/tb_bcd_carpma.sv
// Directed table-driven bench for bcd_carpma plus hand-written handshake/reset sequences.
module tb_bcd_carpma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        basla = 1'b0;
  logic [3:0]  rakam1 = '0, rakam2 = '0, rakam3 = '0;
  logic [5:0]  bolen = '0;
  logic [15:0] carpim;
  logic        mesgul, bitti, hata;

  int errors = 0;
  int checks = 0;

  bcd_carpma #(.BOLEN_W(6), .SONUC_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .basla  (basla),
    .rakam1 (rakam1),
    .rakam2 (rakam2),
    .rakam3 (rakam3),
    .bolen  (bolen),
    .carpim (carpim),
    .mesgul (mesgul),
    .bitti  (bitti),
    .hata   (hata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r1, r2, r3;
    logic [5:0] b;
    int         exp_c;
    int         exp_h;
    int         exp_lat;
    int         exp_mes;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Start at a negedge, drop basla after the start edge, count edges until bitti
  task automatic run_op(input logic [3:0] a, input logic [3:0] b2, input logic [3:0] c,
                        input logic [5:0] m, output int lat, output int mes);
    @(negedge clk);
    rakam1 = a; rakam2 = b2; rakam3 = c; bolen = m; basla = 1'b1;
    @(posedge clk);
    lat = 1;
    mes = 0;
    @(negedge clk);
    basla = 1'b0;
    while (!bitti && lat < 40) begin
      if (mesgul) mes++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Wait until bitti is seen at a negedge, bounded
  task automatic wait_bitti(output int lat);
    lat = 0;
    while (!bitti && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, mes;
    logic [15:0] held;
    int seen;

    tbl[0] = '{4'd1, 4'd2, 4'd5, 6'd4,  500,   0, 10, 9};
    tbl[1] = '{4'd0, 4'd0, 4'd8, 6'd3,  24,    0, 10, 9};
    tbl[2] = '{4'd9, 4'd9, 4'd9, 6'd63, 62937, 0, 10, 9};
    tbl[3] = '{4'd1, 4'hA, 4'd0, 6'd5,  0,     1, 1,  0};
    tbl[4] = '{4'd3, 4'd4, 4'd5, 6'd0,  0,     0, 10, 9};
    tbl[5] = '{4'd0, 4'd0, 4'd0, 6'd7,  0,     0, 10, 9};
    tbl[6] = '{4'd4, 4'd0, 4'd7, 6'd1,  407,   0, 10, 9};
    tbl[7] = '{4'd7, 4'd6, 4'd3, 6'd42, 32046, 0, 10, 9};
    tbl[8] = '{4'd9, 4'hF, 4'd9, 6'd1,  0,     1, 1,  0};

    // Reset state
    #2;
    chk("reset_carpim", carpim, 0);
    chk("reset_mesgul", mesgul, 0);
    chk("reset_bitti", bitti, 0);
    chk("reset_hata", hata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mesgul", mesgul, 0);

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].r1, tbl[i].r2, tbl[i].r3, tbl[i].b, lat, mes);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("v%0d_mesgul_cycles", i), mes, tbl[i].exp_mes);
      chk($sformatf("v%0d_carpim", i), carpim, tbl[i].exp_c);
      chk($sformatf("v%0d_hata", i), hata, tbl[i].exp_h);
      held = carpim;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_bitti_one_cycle", i), bitti, 0);
      chk($sformatf("v%0d_carpim_held", i), carpim, held);
    end

    // hata stays asserted after an invalid operation until the next start
    @(negedge clk);
    chk("hata_held", hata, 1);
    chk("hata_carpim_zero", carpim, 0);

    // basla held high across two operations with inputs changed mid-run
    @(negedge clk);
    rakam1 = 4'd1; rakam2 = 4'd2; rakam3 = 4'd5; bolen = 6'd4; basla = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("held_hata_cleared", hata, 0);
    rakam1 = 4'd0; rakam2 = 4'd2; rakam3 = 4'd5; bolen = 6'd3;
    wait_bitti(lat);
    chk("held_first_latency", lat + 1, 10);
    chk("held_first_carpim", carpim, 500);
    @(posedge clk);
    @(negedge clk);
    chk("held_idle_gap_mesgul", mesgul, 0);
    chk("held_idle_gap_bitti", bitti, 0);
    @(posedge clk);
    @(negedge clk);
    chk("held_second_accepted", mesgul, 1);
    basla = 1'b0;
    wait_bitti(lat);
    chk("held_second_latency", lat + 1, 10);
    chk("held_second_carpim", carpim, 75);

    // Reset asserted while multiplying
    @(posedge clk);
    @(negedge clk);
    rakam1 = 4'd1; rakam2 = 4'd2; rakam3 = 4'd5; bolen = 6'd4; basla = 1'b1;
    @(posedge clk);
    @(negedge clk);
    basla = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_carpim", carpim, 0);
    chk("rst_mesgul", mesgul, 0);
    chk("rst_bitti", bitti, 0);
    chk("rst_hata", hata, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bitti || mesgul) seen++;
    end
    chk("rst_no_resume", seen, 0);
    run_op(4'd2, 4'd5, 4'd0, 6'd2, lat, mes);
    chk("after_rst_latency", lat, 10);
    chk("after_rst_carpim", carpim, 500);
    chk("after_rst_hata", hata, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
